// File: rtl/lh_sync_pkg.sv
// lh_sync_pkg
// Shared definitions for the lighthouse event synchronizer.
//   lh_state_e  : lock state machine encoding (SEARCH, ACQUIRE, LOCKED)
//   LH_DATA_W   : default event payload width (decoder event word)
//   lh_phase_w(): width needed to hold a phase value 0..PERIOD-1
package lh_sync_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lh_state_e;

  localparam int LH_DATA_W = 48;

  function automatic int lh_phase_w(input int period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/lh_phase_counter.sv
// lh_phase_counter
// Modulo-PERIOD free-running phase counter with a synchronous load-to-1.
// Loading 1 (not 0) marks the current cycle as phase 0 of a new period.
// Ports:
//   clk, reset      : clock, synchronous active-high reset (count -> 0)
//   i_load          : force the count to 1 on the next edge
//   o_cnt           : current phase 0..PERIOD-1
//   o_in_window     : cnt <= WINDOW or cnt >= PERIOD-WINDOW
//   o_at_window     : cnt == WINDOW (evaluation cycle)
//   o_at_zero       : cnt == 0
module lh_phase_counter
  import lh_sync_pkg::*;
#(
  parameter int PERIOD = 100,
  parameter int WINDOW = 4,
  parameter int PW     = lh_phase_w(PERIOD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  output logic [PW-1:0] o_cnt,
  output logic          o_in_window,
  output logic          o_at_window,
  output logic          o_at_zero
);

  localparam logic [PW-1:0] CNT_LAST = PW'(PERIOD - 1);
  localparam logic [PW-1:0] WIN_HI   = PW'(WINDOW);
  localparam logic [PW-1:0] WIN_LO   = PW'(PERIOD - WINDOW);

  logic [PW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= PW'(1);
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt       = r_cnt;
  // The window straddles the wrap: tail of one period plus head of the next.
  assign o_in_window = (r_cnt <= WIN_HI) || (r_cnt >= WIN_LO);
  assign o_at_window = (r_cnt == WIN_HI);
  assign o_at_zero   = (r_cnt == '0);

endmodule

// File: rtl/lh_synchronizer.sv
// lh_synchronizer
// Locks a local PERIOD-cycle phase counter to a periodic stream of events
// (lighthouse sweep/sync detections), forwards each event one cycle later
// tagged with its phase, reports lock and emits frame_start while locked.
//
// Optional build macro: LH_SYNC_PHASE_TRACK_EN
//   defined   : while LOCKED, the first in-window event of each period
//               realigns the counter (cnt <= 1), tracking slow drift.
//   undefined : counter is never realigned after acquisition.
//
// Handshake: in_valid is a one-cycle strobe with no back-pressure; every
// cycle with in_valid high produces exactly one cycle of out_valid high on
// the following cycle, carrying that cycle's in_data and phase.
//
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   in_valid      : event strobe (may be high on consecutive cycles)
//   in_data       : event payload
//   out_valid     : in_valid delayed one cycle
//   out_data      : in_data captured on event cycles (holds otherwise)
//   out_phase     : counter value on the event cycle (holds otherwise)
//   locked        : high while in LOCKED
//   frame_start   : high on the cnt==0 cycle while LOCKED
//   o_dbg_state   : current lock state
module lh_synchronizer
  import lh_sync_pkg::*;
#(
  parameter int PERIOD     = 100,
  parameter int WINDOW     = 4,
  parameter int LOCK_COUNT = 4,
  parameter int MISS_LIMIT = 3,
  parameter int DATA_W     = LH_DATA_W,
  localparam int PW        = lh_phase_w(PERIOD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [PW-1:0]     out_phase,
  output logic              locked,
  output logic              frame_start,
  output lh_state_e         o_dbg_state
);

  localparam int HW = $clog2(LOCK_COUNT + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam logic [HW-1:0] HITS_MAX = HW'(LOCK_COUNT);
  localparam logic [MW-1:0] MISS_MAX = MW'(MISS_LIMIT);

  lh_state_e         r_state, w_state_nxt;
  logic [HW-1:0]     r_hits, w_hits_nxt, w_hits_inc;
  logic [MW-1:0]     r_misses, w_misses_nxt, w_misses_inc;
  logic              r_seen, w_seen_nxt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [PW-1:0]     r_out_phase;

  logic [PW-1:0]     w_cnt;
  logic              w_load, w_in_window, w_at_window, w_at_zero, w_eval_hit;

  lh_phase_counter #(
    .PERIOD (PERIOD),
    .WINDOW (WINDOW),
    .PW     (PW)
  ) u_cnt (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .o_cnt       (w_cnt),
    .o_in_window (w_in_window),
    .o_at_window (w_at_window),
    .o_at_zero   (w_at_zero)
  );

  // An event on the evaluation cycle itself still counts for that period.
  assign w_eval_hit   = r_seen | in_valid;
  assign w_hits_inc   = (r_hits == HITS_MAX) ? r_hits : r_hits + 1'b1;
  assign w_misses_inc = (r_misses == MISS_MAX) ? r_misses : r_misses + 1'b1;

  always_comb begin
    w_state_nxt  = r_state;
    w_hits_nxt   = r_hits;
    w_misses_nxt = r_misses;
    w_seen_nxt   = r_seen;
    w_load       = 1'b0;

    if (in_valid && w_in_window) w_seen_nxt = 1'b1;
    if (w_at_window)             w_seen_nxt = 1'b0;

    case (r_state)
      SEARCH: begin
        if (in_valid) begin
          w_load      = 1'b1;
          w_seen_nxt  = 1'b1;
          w_hits_nxt  = '0;
          w_state_nxt = ACQUIRE;
        end
      end
      ACQUIRE: begin
        if (w_at_window) begin
          if (w_eval_hit) begin
            w_hits_nxt = w_hits_inc;
            if (w_hits_inc == HITS_MAX) begin
              w_state_nxt  = LOCKED;
              w_misses_nxt = '0;
            end
          end else begin
            w_state_nxt = SEARCH;
            w_hits_nxt  = '0;
          end
        end
      end
      LOCKED: begin
        if (w_at_window) begin
          if (w_eval_hit) begin
            w_misses_nxt = '0;
          end else begin
            w_misses_nxt = w_misses_inc;
            if (w_misses_inc == MISS_MAX) begin
              w_state_nxt = SEARCH;
              w_hits_nxt  = '0;
            end
          end
        end
`ifdef LH_SYNC_PHASE_TRACK_EN
        // r_seen low means no in-window event yet this period. Setting seen
        // after the realign keeps the shifted evaluation from reading a miss.
        if (in_valid && w_in_window && !r_seen && (w_state_nxt == LOCKED)) begin
          w_load     = 1'b1;
          w_seen_nxt = 1'b1;
        end
`endif
      end
      default: begin
        w_state_nxt = SEARCH;
        w_hits_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= SEARCH;
      r_hits      <= '0;
      r_misses    <= '0;
      r_seen      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_phase <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_hits      <= w_hits_nxt;
      r_misses    <= w_misses_nxt;
      r_seen      <= w_seen_nxt;
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out_data  <= in_data;
        r_out_phase <= w_cnt;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_phase   = r_out_phase;
  assign locked      = (r_state == LOCKED);
  assign frame_start = (r_state == LOCKED) && w_at_zero;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_lh_synchronizer.sv
// tb_lh_synchronizer
// Self-checking bench for lh_synchronizer (PERIOD=100, WINDOW=4,
// LOCK_COUNT=4, MISS_LIMIT=3, DATA_W=48). Forwarded events are checked by a
// scoreboard; lock/frame/state behaviour by a vector table and sequences.
module tb_lh_synchronizer;
  import lh_sync_pkg::*;

  localparam int DW = 48;
  localparam int PW = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [PW-1:0] out_phase;
  logic          locked;
  logic          frame_start;
  lh_state_e     dbg_state;

  lh_synchronizer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_phase   (out_phase),
    .locked      (locked),
    .frame_start (frame_start),
    .o_dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            ph_q[$];   // expected phase, -1 = not predicted
  logic [DW-1:0] sb_d;
  int            sb_p;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected @%0t: out_valid=1 data %0h, expected no output", $time, out_data);
      end else begin
        sb_d = exp_q.pop_front();
        sb_p = ph_q.pop_front();
        check("sb_data", 64'(out_data), 64'(sb_d));
        if (sb_p >= 0) check("sb_phase", 64'(out_phase), 64'(sb_p));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic vld, input logic [DW-1:0] d, input int ph);
    reset    = rst;
    in_valid = vld;
    in_data  = d;
    if (!rst && vld) begin
      exp_q.push_back(d);
      ph_q.push_back(ph);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {16'($urandom_range(0, 16'hffff)), 32'($urandom())};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic          vld;
    logic [DW-1:0] d;
    int            ph;
    logic          e_ov;
    logic [DW-1:0] e_od;
    lh_state_e     e_st;
  } vec_t;

  vec_t vecs[9];
  localparam logic [DW-1:0] ALL1 = 48'hffff_ffff_ffff;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset held 3 cycles with in_valid high, then early ACQUIRE datapath.
    vecs[0] = '{1'b1, 1'b1, 48'h0000_0000_aaaa, -1, 1'b0, 48'h0,         SEARCH};
    vecs[1] = '{1'b1, 1'b1, 48'h0000_0000_5555, -1, 1'b0, 48'h0,         SEARCH};
    vecs[2] = '{1'b1, 1'b1, 48'h0000_0000_1234, -1, 1'b0, 48'h0,         SEARCH};
    vecs[3] = '{1'b0, 1'b1, 48'h0000_00ab_cdef,  0, 1'b1, 48'hab_cdef,   ACQUIRE};
    vecs[4] = '{1'b0, 1'b0, 48'h0000_0099_9999, -1, 1'b0, 48'hab_cdef,   ACQUIRE};
    vecs[5] = '{1'b0, 1'b1, 48'h0,               2, 1'b1, 48'h0,         ACQUIRE};
    vecs[6] = '{1'b0, 1'b1, ALL1,                3, 1'b1, ALL1,          ACQUIRE};
    vecs[7] = '{1'b0, 1'b0, 48'h1,              -1, 1'b0, ALL1,          ACQUIRE};
    vecs[8] = '{1'b1, 1'b0, 48'h0,              -1, 1'b0, 48'h0,         SEARCH};

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].d, vecs[i].ph);
      step();
      check("tbl_out_valid",   64'(out_valid),   64'(vecs[i].e_ov));
      check("tbl_out_data",    64'(out_data),    64'(vecs[i].e_od));
      check("tbl_state",       64'(dbg_state),   64'(vecs[i].e_st));
      check("tbl_locked",      64'(locked),      64'(0));
      check("tbl_frame_start", 64'(frame_start), 64'(0));
    end

    // Continuous valid for 521 cycles, then silence: lock at 304, three
    // missed evaluations (604, 704, 804) drop it, frame_start at 399..799.
    for (int k = 0; k <= 920; k++) begin
      drive(1'b0, (k <= 520), ALL1, k % 100);
      step();
      check("cont_locked", 64'(locked), 64'((k >= 304) && (k < 804)));
      check("cont_frame_start", 64'(frame_start),
            64'((k >= 399) && (k <= 799) && ((k - 399) % 100 == 0)));
    end

    // One seed pulse, then a pulse every 100 cycles starting 2 late.
    drive(1'b1, 1'b0, '0, -1);
    step();
    for (int k = 0; k <= 410; k++) begin
      drive(1'b0, (k == 0) || (k >= 102 && (k - 102) % 100 == 0), rand_data(), (k == 0) ? 0 : 2);
      step();
      check("late_locked", 64'(locked), 64'(k >= 304));
    end

    // Reset while locked (in_valid high), then full re-acquisition.
    drive(1'b1, 1'b1, rand_data(), -1);
    step();
    check("rst_locked",      64'(locked),      64'(0));
    check("rst_frame_start", 64'(frame_start), 64'(0));
    check("rst_state",       64'(dbg_state),   64'(SEARCH));
    check("rst_out_valid",   64'(out_valid),   64'(0));
    for (int k = 0; k <= 305; k++) begin
      drive(1'b0, 1'b1, rand_data(), k % 100);
      step();
      check("reacq_locked", 64'(locked), 64'(k >= 304));
      check("reacq_frame_start", 64'(frame_start), 64'(0));
    end

    // Seed pulse, then an event at phase 50: evaluation at 104 misses.
    drive(1'b1, 1'b0, '0, -1);
    step();
    for (int k = 0; k <= 110; k++) begin
      drive(1'b0, (k == 0) || (k == 50), rand_data(), k);
      step();
      check("off_state", 64'(dbg_state), 64'((k < 104) ? ACQUIRE : SEARCH));
      check("off_locked", 64'(locked), 64'(0));
    end

    drive(1'b0, 1'b0, '0, -1);
    repeat (3) step();
    check("sb_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lh_synchronizer.md
Name: lh_synchronizer

Overview:
- Locks a local PERIOD-cycle phase counter to a periodic stream of valid events, such as lighthouse sweep/sync detections.
- Passes each event through registered, tagged with its phase within the period.
- Reports lock status and emits a frame-start pulse while locked.
- Sits between the pulse decoder (48-bit event words) and downstream timing/angle logic.

Parameters:
- PERIOD, 100: nominal event period in clk cycles; must be at least 2*WINDOW+2.
- WINDOW, 4: tolerance in cycles either side of expected phase 0; an event counts as on time when cnt <= WINDOW or cnt >= PERIOD-WINDOW.
- LOCK_COUNT, 4: consecutive on-time periods needed to declare lock.
- MISS_LIMIT, 3: consecutive missed periods that drop lock.
- DATA_W, 48: event data width.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: event strobe; may stay high on consecutive cycles.
- in_data, input, DATA_W: event payload, sampled when in_valid is high.
- out_valid, output, 1: registered copy of in_valid.
- out_data, output, DATA_W: registered copy of in_data.
- out_phase, output, PW = $clog2(PERIOD): value of cnt on the event cycle.
- locked, output, 1: high while in LOCKED state.
- frame_start, output, 1: one-cycle pulse when cnt wraps to 0 while locked.

Behaviour:
- Reset values: every output 0; cnt=0; state=SEARCH; hits=0; misses=0; seen=0.
- Phase counter cnt:
  - Free-running 0..PERIOD-1; wraps from PERIOD-1 to 0.
  - Realigned only as stated below.
- Datapath latency is 1 cycle:
  - out_valid <= in_valid.
  - out_data <= in_data; data holds its last value when in_valid is low.
  - out_phase <= cnt, captured on the event cycle.
- seen flag:
  - Set by any in_valid while cnt is inside the window.
  - Cleared at each evaluation.
  - The window spans the wrap, from PERIOD-WINDOW of one period through WINDOW of the next.
- Evaluation occurs on the edge where cnt==WINDOW. The evaluation result is seen OR an in_valid in that same cycle.
- State SEARCH:
  - First in_valid sets cnt<=1 (event defines phase 0), seen<=1, hits<=0, state<=ACQUIRE.
  - Evaluations are ignored in SEARCH.
- State ACQUIRE:
  - Eval hit: hits++. When hits reaches LOCK_COUNT: state<=LOCKED, locked<=1 on that same edge, misses<=0.
  - Eval miss: state<=SEARCH, hits<=0.
- State LOCKED:
  - Eval hit: misses<=0.
  - Eval miss: misses++. When misses reaches MISS_LIMIT: state<=SEARCH, locked<=0, hits<=0.
- Events outside the window never change state or seen; they are still forwarded with their phase.
- frame_start: high for one cycle on the cycle cnt==0 when state==LOCKED. Not generated on the realignment edge in SEARCH.
- Counter widths:
  - hits and misses saturate and never wrap.
  - cnt has width PW and never exceeds PERIOD-1.
- reset mid-operation returns everything to reset values on the next edge, regardless of in_valid.

Optional Feature:
- Macro LH_SYNC_PHASE_TRACK_EN.
- When defined, in LOCKED the first in-window event of each period realigns the counter: cnt<=1 on the next edge. A one-time frame_start slip is allowed.
- When undefined, the counter is never realigned after acquisition; drift shows only as out_phase offsets and eventual lock loss.

Decomposition:
- Shared package lh_sync_pkg holds:
  - state enum {SEARCH, ACQUIRE, LOCKED};
  - DATA_W default;
  - function computing PW.
- One natural sub-module, lh_phase_counter: modulo-PERIOD counter with load-to-1 and wrap/at-WINDOW flags.

Test Plan:
- Reset: hold reset 3 cycles with in_valid=1 -> all outputs 0, state SEARCH; no lock.
- Continuous valid (PERIOD=100, in_valid=1 from edge t0, in_data=48'hffffffffffff):
  - out_valid=1 and out_data=48'hffffffffffff from t0+1;
  - locked rises at edge t0+304;
  - frame_start pulses every 100 cycles afterwards.
- Drop valid after lock (in_valid=0 at edge td) -> locked falls after the 3rd missed evaluation (≤ td+300 cycles); frame_start stops.
- Single pulse every 100 cycles, 2 cycles late (within WINDOW=4) -> lock achieved, out_phase=2 on each event.
- Pulses every 100 cycles at phase 50 during ACQUIRE -> eval miss, return to SEARCH, locked stays 0.
- Reset asserted while locked -> locked=0 and frame_start=0 next edge; re-acquisition needs a full LOCK_COUNT periods.
